// File: rtl/expansion_shiftreg_pkg.sv
// Shared definitions for the expansion shift-register chain driver.
//   shreg_state_e : frame sequencer states
//   LATCH_TICKS   : ticks spent in the latch phase (load low + load high)
//   cnt_width()   : counter width able to hold 0..n-1 (never less than one bit)
package expansion_shiftreg_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StShLo,
    StShHi,
    StLatchLo,
    StLatchHi
  } shreg_state_e;

  localparam int unsigned LATCH_TICKS = 2;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/expansion_shiftreg_chain_tick_gen.sv
// Half-bit-period tick generator for the shift-register chain.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   run   : count while high; low holds the counter at zero
//   tick  : one-clk pulse on the terminal count DIVIDER-1
module shiftreg_tick_gen
  import expansion_shiftreg_pkg::*;
#(
  parameter int unsigned DIVIDER = 135
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(DIVIDER);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            at_end;

  assign at_end = (cnt_q == CntW'(DIVIDER - 1));
  assign tick   = run & at_end;

  always_comb begin
    cnt_d = cnt_q;
    if (!run || at_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/expansion_shiftreg_chain.sv
// Daisy-chain driver for 74HC595 outputs and 74HC165 inputs sharing one CLOCK/LOAD pair.
//   clk, rst_n  : system clock, synchronous active-low reset
//   enable      : run frames back to back while high; a running frame always completes
//   data_out    : word shifted to the 595 chain, snapshotted at frame start
//   data_in     : word captured from the 165 chain, updated atomically at frame end
//   frame_done  : one-clk pulse when data_in has been refreshed
//   in_changed  : one-clk pulse alongside frame_done when data_in took a new value
//   SHIFT_OUT   : serial data to the 595 chain
//   SHIFT_IN    : serial data from the 165 chain
//   SHIFT_CLK   : shift clock shared by both chains
//   SHIFT_LOAD  : low = 165 parallel load; rising edge latches the 595 outputs
module expansion_shiftreg_chain
  import expansion_shiftreg_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DIVIDER   = 135,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned DEBOUNCE  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] data_in,
  output logic             frame_done,
  output logic             in_changed,
  output logic             SHIFT_OUT,
  input  logic             SHIFT_IN,
  output logic             SHIFT_CLK,
  output logic             SHIFT_LOAD
);

  // The slot counter indexes shift bits 0..WIDTH-1, then keeps counting through the latch phase.
  localparam int unsigned IdxW = cnt_width(WIDTH);
  localparam int unsigned CntW = cnt_width(WIDTH + LATCH_TICKS);

  shreg_state_e     state_q, state_d;
  logic [CntW-1:0]  bit_q, bit_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] raw_q, raw_d;
  logic [WIDTH-1:0] prev_raw_q, prev_raw_d;
  logic [WIDTH-1:0] data_in_q, data_in_d;
  logic             done_q, done_d;
  logic             chg_q, chg_d;
  logic             sout_q, sout_d;
  logic             sclk_q, sclk_d;
  logic             sload_q, sload_d;
  logic             priming_q, priming_d;
  logic             first_bit;
  logic             tick;
  logic             run;

  // Maps the serial position to the word bit it carries.
  function automatic logic [IdxW-1:0] bit_index(input logic [IdxW-1:0] n);
    return (MSB_FIRST != 0) ? IdxW'(WIDTH - 1) - n : n;
  endfunction

  assign run       = (state_q != StIdle);
  assign first_bit = (MSB_FIRST != 0) ? data_out[WIDTH-1] : data_out[0];

  shiftreg_tick_gen #(
    .DIVIDER(DIVIDER)
  ) u_tick_gen (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .tick (tick)
  );

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    shadow_d   = shadow_q;
    raw_d      = raw_q;
    prev_raw_d = prev_raw_q;
    data_in_d  = data_in_q;
    done_d     = 1'b0;
    chg_d      = 1'b0;
    sout_d     = sout_q;
    priming_d  = priming_q;

    unique case (state_q)
      StIdle: begin
        if (enable) begin
          shadow_d = data_out;
          bit_d    = '0;
          sout_d   = first_bit;
          state_d  = StShLo;
        end
      end
      StShLo: begin
        // Sampled on the same clk that raises SHIFT_CLK, i.e. before the 165 shifts.
        if (tick) begin
          raw_d[bit_index(bit_q[IdxW-1:0])] = SHIFT_IN;
          state_d = StShHi;
        end
      end
      StShHi: begin
        if (tick) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == CntW'(WIDTH - 1)) begin
            state_d = StLatchLo;
          end else begin
            sout_d  = shadow_q[bit_index(bit_d[IdxW-1:0])];
            state_d = StShLo;
          end
        end
      end
      StLatchLo: begin
        // Load stays low for all latch ticks but the last one.
        if (tick) begin
          bit_d = bit_q + 1'b1;
          if (bit_q == CntW'(WIDTH + LATCH_TICKS - 2)) begin
            state_d = StLatchHi;
          end
        end
      end
      StLatchHi: begin
        if (tick) begin
          if (priming_q) begin
            // Bits shifted in the first frame predate any load pulse.
            priming_d = 1'b0;
          end else begin
            if ((DEBOUNCE == 0) || (raw_q == prev_raw_q)) begin
              data_in_d = raw_q;
            end
            if (DEBOUNCE != 0) begin
              prev_raw_d = raw_q;
            end
            done_d = 1'b1;
            chg_d  = (data_in_d != data_in_q);
          end
          if (enable) begin
            shadow_d = data_out;
            bit_d    = '0;
            sout_d   = first_bit;
            state_d  = StShLo;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Pin levels are registered so they follow the state with no decode glitches.
    sclk_d  = (state_d == StShHi);
    sload_d = (state_d != StLatchLo);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bit_q      <= '0;
      shadow_q   <= '0;
      raw_q      <= '0;
      prev_raw_q <= '0;
      data_in_q  <= '0;
      done_q     <= 1'b0;
      chg_q      <= 1'b0;
      sout_q     <= 1'b0;
      sclk_q     <= 1'b0;
      sload_q    <= 1'b1;
      priming_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      shadow_q   <= shadow_d;
      raw_q      <= raw_d;
      prev_raw_q <= prev_raw_d;
      data_in_q  <= data_in_d;
      done_q     <= done_d;
      chg_q      <= chg_d;
      sout_q     <= sout_d;
      sclk_q     <= sclk_d;
      sload_q    <= sload_d;
      priming_q  <= priming_d;
    end
  end

  assign data_in    = data_in_q;
  assign frame_done = done_q;
  assign in_changed = chg_q;
  assign SHIFT_OUT  = sout_q;
  assign SHIFT_CLK  = sclk_q;
  assign SHIFT_LOAD = sload_q;

endmodule

// File: doc/expansion_shiftreg_chain.md
Name: expansion_shiftreg_chain

Overview:
Parametrised successor to the 8-bit expansion shift-register driver. It drives a daisy chain of 74HC595 output and 74HC165 input registers through one shared CLOCK/LOAD pair, for any WIDTH. Compared with the 8-bit driver it adds:
- atomic snapshot of outputs and inputs;
- bit order select;
- run/stop control;
- a priming frame after reset;
- optional input debounce;
- frame_done and in_changed strobes.

It sits between the rio top level (which applies pin inversion) and the expansion header.

Parameters:
WIDTH, 8, chain length in bits (multiple of 8, 8..64)
DIVIDER, 135, clk cycles per tick (>=1); one tick is one half bit period
MSB_FIRST, 1, 1: data_out[WIDTH-1] is shifted first and the first sampled bit lands in data_in[WIDTH-1]; 0: bit 0 first
DEBOUNCE, 0, 1: data_in updates only when two consecutive raw frames are equal

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
enable  in  1  run frames continuously while high
data_out  in  WIDTH  parallel output word
data_in  out  WIDTH  parallel input word, updated atomically at frame end
frame_done  out  1  one-clk pulse when data_in has been refreshed
in_changed  out  1  one-clk pulse, coincident with frame_done, when the new data_in differs from the old one
SHIFT_OUT  out  1  serial data to the 595 chain
SHIFT_IN  in  1  serial data from the 165 chain
SHIFT_CLK  out  1  shift clock shared by both chains
SHIFT_LOAD  out  1  low pulse = 165 parallel load and 595 RCLK low; rising edge latches the 595 outputs

Behaviour:
- Reset values (rst_n=0 sampled on a clk edge): SHIFT_CLK=0, SHIFT_LOAD=1, SHIFT_OUT=0, data_in=0, frame_done=0, in_changed=0, state IDLE, tick counter 0, bit counter 0, priming flag set.
- Tick generator: counts 0..DIVIDER-1 and emits a one-clk tick on the terminal count. It runs only outside IDLE; entering IDLE clears it.
- States and transitions:
  - IDLE: leaves on the first clk with enable=1. Copies data_out into the shadow register and clears the bit counter; the next state is SH_LO.
  - SH_LO (1 tick): SHIFT_CLK=0; SHIFT_OUT = current shadow bit.
  - At the SH_LO to SH_HI transition: SHIFT_IN is sampled into the raw capture register at the same clk as SHIFT_CLK rises.
  - SH_HI (1 tick): SHIFT_CLK=1. The bit counter advances at the end of the tick; after bit WIDTH-1 the next state is LATCH_LO, otherwise SH_LO.
  - LATCH_LO (1 tick): SHIFT_CLK=0, SHIFT_LOAD=0.
  - LATCH_HI (1 tick): SHIFT_LOAD=1; the rising edge latches the 595 outputs.
  - End of LATCH_HI: commit step (below). Then, if enable=1, copy data_out to the shadow and go to SH_LO; otherwise go to IDLE.
- Frame length is (2*WIDTH+2)*DIVIDER clk cycles; WIDTH=8, DIVIDER=135 gives 2430.
- SHIFT_OUT holds its value through SH_HI; it changes only on entry to SH_LO.
- Output latency: a data_out value sampled at frame start appears on the 595 pins at the LATCH_HI rising edge of the same frame.
- Input latency: pins loaded during the LATCH_LO of frame N are reported at the end of frame N+1.
- Commit step (end of LATCH_HI):
  - Priming frame (first frame after reset): captured bits are stale. No update, no strobes; the priming flag clears.
  - DEBOUNCE=0: data_in <= raw.
  - DEBOUNCE=1: data_in <= raw only if raw equals the previous raw frame. The previous raw register is always updated.
  - frame_done=1 for one clk whenever the commit is not a priming commit, even if data_in was unchanged.
  - in_changed=1 only if the new data_in differs from the old data_in.
- enable falling mid-frame: the current frame completes, including latch and commit; the block then idles.
- data_out changing mid-frame has no effect until the next frame's snapshot.
- Reset mid-frame: immediate return to reset values. The partial frame is discarded and the priming flag is set again.
- DIVIDER=1: one tick per clk, which must still be fully functional.

Decomposition:
- Package expansion_shiftreg_pkg holds:
  - the state enum (IDLE, SH_LO, SH_HI, LATCH_LO, LATCH_HI);
  - a clog2-based width function for the tick and bit counters;
  - a LATCH_TICKS=2 constant.
- One sub-module, shiftreg_tick_gen (params DIVIDER; ports clk, rst_n, run, tick), is instantiated once.

Test Plan:
- Reset then enable=1, WIDTH=8, MSB_FIRST=1, data_out=8'hA5 -> SHIFT_OUT sequence 1,0,1,0,0,1,0,1 on SHIFT_CLK rising edges; one SHIFT_LOAD low pulse per frame; no frame_done on the first (priming) frame.
- Model the 165 chain with pins 8'h3C -> the second completed frame gives data_in=8'h3C with frame_done=1 and in_changed=1; the third frame gives frame_done=1, in_changed=0.
- WIDTH=16, MSB_FIRST=0, DIVIDER=1, data_out=16'h0001 -> the first SHIFT_OUT bit is 1 and the other 15 bits are 0; frame length is 34 clk.
- DEBOUNCE=1, pins toggle 8'h00/8'hFF every frame -> data_in stays 8'h00 and in_changed never fires; pins held at 8'hFF for two frames -> data_in=8'hFF.
- Drop enable at bit 3 of a frame -> the frame finishes with its LATCH pulse, then the block stays in IDLE with SHIFT_LOAD=1 and SHIFT_CLK=0.
- Assert rst_n=0 for one clk mid-shift -> the next clk shows all reset values; after re-enable, a priming frame occurs again with no frame_done.
